// File: rtl/message_screen.sv
// Full-screen 640x480@60 text overlay: scaled message with typewriter reveal over a background stream.
// Optional blink of the fully revealed message is enabled with `define MSG_BLINK_EN.
module message_screen #(
    parameter int          MSG_LEN       = 10,
    parameter int          COL           = 35,
    parameter int          ROW           = 9,
    parameter int          SCALE         = 1,
    parameter logic [7:0]  TEXT_RGB      = 8'b000_000_11,
    parameter int          REVEAL_FRAMES = 8,
    parameter int          BLINK_FRAMES  = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 show,
    input  logic [8*MSG_LEN-1:0] msg,
    input  logic [7:0]           bg,
    input  logic [7:0]           font_data,
    output logic [11:0]          font_addr,
    output logic [9:0]           bg_x,
    output logic [9:0]           bg_y,
    output logic [2:0]           r,
    output logic [2:0]           g,
    output logic [1:0]           b,
    output logic                 hs,
    output logic                 vs,
    output logic                 frame_start,
    output logic                 revealed
);
    localparam int SH   = (SCALE == 2) ? 1 : 0;
    localparam int CV_W = $clog2(MSG_LEN + 1);
    localparam int RF_W = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;

    typedef enum logic [1:0] {HIDDEN = 2'd0, REVEAL = 2'd1, SHOWN = 2'd2} state_t;

    logic [1:0]         r_div;
    logic [9:0]         r_hcount, r_vcount;
    logic               w_tick, w_fs;
    state_t             r_state, w_state_nxt;
    logic [CV_W-1:0]    r_cvis, w_cvis_nxt;
    logic [RF_W-1:0]    r_fcnt, w_fcnt_nxt;
    logic               w_text_on;
    logic signed [10:0] w_x, w_y, w_c, w_r;
    logic               w_active, w_in_row, w_txt;
    logic [3:0]         w_grow;
    logic [2:0]         w_gcol;
    logic [7:0]         w_code;
    logic               r_txt_p1, r_act_p1, r_hs_p1, r_vs_p1;
    logic [2:0]         r_gcol_p1;

    assign w_tick   = (r_div == 2'd3);
    assign w_fs     = w_tick && (r_hcount == 10'd0) && (r_vcount == 10'd0);
    assign revealed = (r_state == SHOWN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div       <= 2'd0;
            r_hcount    <= 10'd0;
            r_vcount    <= 10'd0;
            frame_start <= 1'b0;
        end else begin
            r_div       <= r_div + 2'd1;
            frame_start <= w_fs;
            if (w_tick) begin
                if (r_hcount == 10'd799) begin
                    r_hcount <= 10'd0;
                    r_vcount <= (r_vcount == 10'd520) ? 10'd0 : r_vcount + 10'd1;
                end else begin
                    r_hcount <= r_hcount + 10'd1;
                end
            end
        end
    end

    // Reveal state machine, evaluated once per frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= HIDDEN;
            r_cvis  <= '0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cvis  <= w_cvis_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cvis_nxt  = r_cvis;
        w_fcnt_nxt  = r_fcnt;
        if (w_fs) begin
            case (r_state)
                HIDDEN: begin
                    w_cvis_nxt = '0;
                    w_fcnt_nxt = '0;
                    if (show) begin
                        if (REVEAL_FRAMES == 0) begin
                            w_state_nxt = SHOWN;
                            w_cvis_nxt  = CV_W'(MSG_LEN);
                        end else begin
                            w_state_nxt = REVEAL;
                        end
                    end
                end
                REVEAL: begin
                    if (!show) begin
                        w_state_nxt = HIDDEN;
                        w_cvis_nxt  = '0;
                        w_fcnt_nxt  = '0;
                    end else if (r_fcnt == RF_W'(REVEAL_FRAMES - 1)) begin
                        w_fcnt_nxt = '0;
                        w_cvis_nxt = r_cvis + CV_W'(1);
                        if (r_cvis == CV_W'(MSG_LEN - 1))
                            w_state_nxt = SHOWN;
                    end else begin
                        w_fcnt_nxt = r_fcnt + RF_W'(1);
                    end
                end
                SHOWN: begin
                    if (!show) begin
                        w_state_nxt = HIDDEN;
                        w_cvis_nxt  = '0;
                        w_fcnt_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = HIDDEN;
                    w_cvis_nxt  = '0;
                    w_fcnt_nxt  = '0;
                end
            endcase
        end
    end

`ifdef MSG_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BF_W-1:0] r_bcnt;
    logic            r_text_on;

    // Counter restarts on every frame that is not a continuation of SHOWN, so the first SHOWN frame is lit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcnt    <= '0;
            r_text_on <= 1'b1;
        end else if (w_fs) begin
            if (r_state == SHOWN && w_state_nxt == SHOWN) begin
                if (r_bcnt == BF_W'(BLINK_FRAMES - 1)) begin
                    r_bcnt    <= '0;
                    r_text_on <= ~r_text_on;
                end else begin
                    r_bcnt <= r_bcnt + BF_W'(1);
                end
            end else begin
                r_bcnt    <= '0;
                r_text_on <= 1'b1;
            end
        end
    end
    assign w_text_on = r_text_on;
`else
    assign w_text_on = 1'b1;
`endif

    // T0: cell geometry from the raw counters
    always_comb begin
        w_x      = $signed({1'b0, r_hcount}) - 11'sd144;
        w_y      = $signed({1'b0, r_vcount}) - 11'sd31;
        w_c      = (w_x >>> (3 + SH)) - 11'(COL);
        w_r      = (w_y >>> (4 + SH)) - 11'(ROW);
        w_grow   = w_y[3+SH:SH];
        w_gcol   = w_x[2+SH:SH];
        w_active = (r_hcount >= 10'd144) && (r_hcount <= 10'd783) &&
                   (r_vcount >= 10'd31)  && (r_vcount <= 10'd510);
        w_in_row = w_active && (w_r == 11'sd0) && (w_c >= 11'sd0) && (w_c < 11'(MSG_LEN));
        w_code   = 8'h00;
        for (int k = 0; k < MSG_LEN; k++) begin
            if (w_in_row && (w_c == 11'(k)))
                w_code = msg[8*(MSG_LEN-1-k) +: 8];
        end
        w_txt    = w_in_row && ($unsigned(w_c) < 11'(r_cvis)) && w_text_on && (w_code != 8'h00);
    end

    // T1: ROM addresses and delayed control
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            font_addr <= 12'd0;
            bg_x      <= 10'd0;
            bg_y      <= 10'd0;
            r_txt_p1  <= 1'b0;
            r_act_p1  <= 1'b0;
            r_hs_p1   <= 1'b0;
            r_vs_p1   <= 1'b0;
        end else if (w_tick) begin
            font_addr <= {w_code, w_grow};
            bg_x      <= w_active ? w_x[9:0] : 10'd0;
            bg_y      <= w_active ? w_y[9:0] : 10'd0;
            r_txt_p1  <= w_txt;
            r_act_p1  <= w_active;
            r_hs_p1   <= (r_hcount >= 10'd96);
            r_vs_p1   <= (r_vcount >= 10'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (w_tick)
            r_gcol_p1 <= w_gcol;
    end

    // T2: colour select, sync aligned with colour
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {r, g, b} <= 8'h00;
            hs        <= 1'b0;
            vs        <= 1'b0;
        end else if (w_tick) begin
            if (r_txt_p1 && font_data[3'd7 - r_gcol_p1])
                {r, g, b} <= TEXT_RGB;
            else if (r_act_p1)
                {r, g, b} <= bg;
            else
                {r, g, b} <= 8'h00;
            hs <= r_hs_p1;
            vs <= r_vs_p1;
        end
    end
endmodule

// File: tb/tb_message_screen.sv
// Directed bench for message_screen: sync timing, fetch/latency, reveal, hide, scale 2 and blink.
// Counters are fast-forwarded by briefly forcing the DUT's h/v counters.
module tb_message_screen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, show_a, show_b;
    logic [79:0] msg_a;
    logic [31:0] msg_b;
    logic [7:0]  bg_a, bg_b, fd_a, fd_b;
    logic [11:0] fa_a, fa_b;
    logic [9:0]  bgx_a, bgy_a, bgx_b, bgy_b;
    logic [2:0]  r_a, g_a, r_b, g_b;
    logic [1:0]  b_a, b_b;
    logic        hs_a, vs_a, fs_a, rev_a, hs_b, vs_b, fs_b, rev_b;
    logic [7:0]  rgb_a, rgb_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0]  gh, gv;
    logic [11:0] p_fa_a, p_fa_b;
    logic [9:0]  p_bgx_a, p_bgy_a;
    logic [7:0]  p_rgb_a, p_rgb_b;
    int          low;

`ifdef MSG_BLINK_EN
    localparam logic [7:0] BLINK_OFF = 8'h99;
`else
    localparam logic [7:0] BLINK_OFF = 8'h03;
`endif

    // Font model: code 0 would be solid, other rows are code ^ row
    function automatic logic [7:0] font_fn(input logic [11:0] a);
        if (a[11:4] == 8'h00) return 8'hFF;
        return a[11:4] ^ {4'h0, a[3:0]};
    endfunction

    assign fd_a  = font_fn(fa_a);
    assign fd_b  = font_fn(fa_b);
    assign bg_a  = {1'b1, bgx_a[6:0]};
    assign bg_b  = {1'b1, bgx_b[6:0]};
    assign rgb_a = {r_a, g_a, b_a};
    assign rgb_b = {r_b, g_b, b_b};

    message_screen #(.MSG_LEN(10), .COL(35), .ROW(9), .SCALE(1), .TEXT_RGB(8'h03),
                     .REVEAL_FRAMES(2), .BLINK_FRAMES(3)) u_a (
        .clk(clk), .rst(rst), .show(show_a), .msg(msg_a), .bg(bg_a), .font_data(fd_a),
        .font_addr(fa_a), .bg_x(bgx_a), .bg_y(bgy_a), .r(r_a), .g(g_a), .b(b_a),
        .hs(hs_a), .vs(vs_a), .frame_start(fs_a), .revealed(rev_a));

    message_screen #(.MSG_LEN(4), .COL(15), .ROW(4), .SCALE(2), .TEXT_RGB(8'h03),
                     .REVEAL_FRAMES(0), .BLINK_FRAMES(30)) u_b (
        .clk(clk), .rst(rst), .show(show_b), .msg(msg_b), .bg(bg_b), .font_data(fd_b),
        .font_addr(fa_b), .bg_x(bgx_b), .bg_y(bgy_b), .r(r_b), .g(g_b), .b(b_b),
        .hs(hs_b), .vs(vs_b), .frame_start(fs_b), .revealed(rev_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) repeat (4) @(negedge clk);
    endtask

    // Called right after a tick edge; jumps both instances' counters
    task goto(input int h, input int v);
        gh = 10'(h);
        gv = 10'(v);
        force u_a.r_hcount = gh;
        force u_a.r_vcount = gv;
        force u_b.r_hcount = gh;
        force u_b.r_vcount = gv;
        #1;
        release u_a.r_hcount;
        release u_a.r_vcount;
        release u_b.r_hcount;
        release u_b.r_vcount;
    endtask

    task next_frame();
        goto(799, 520);
        tick_n(2);
    endtask

    task probe(input int h, input int v);
        goto(h, v);
        tick_n(1);
        p_fa_a  = fa_a;
        p_fa_b  = fa_b;
        p_bgx_a = bgx_a;
        p_bgy_a = bgy_a;
        tick_n(1);
        p_rgb_a = rgb_a;
        p_rgb_b = rgb_b;
    endtask

    initial begin
        rst    = 1'b0;
        show_a = 1'b0;
        show_b = 1'b1;
        msg_a  = "GAME OVER!";
        msg_b  = {"G", 8'h00, "AB"};
        repeat (10) @(negedge clk);
        chk("rst_rgb", rgb_a, 8'h00);
        chk("rst_sync", {hs_a, vs_a}, 2'b00);
        chk("rst_faddr", fa_a, 12'h000);
        chk("rst_bgxy", {bgx_a, bgy_a}, 20'h0);
        chk("rst_fs", fs_a, 1'b0);
        chk("rst_rev", {rev_a, rev_b}, 2'b00);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("fs_early", fs_a, 1'b0);
        @(negedge clk);
        chk("fs_first", fs_a, 1'b1);
        chk("rev_b_first", rev_b, 1'b1);
        chk("rev_a_idle", rev_a, 1'b0);

        low = 0;
        for (int k = 2; k <= 801; k++) begin
            tick_n(1);
            if (hs_a == 1'b0) low++;
            if (k == 2)  chk("fs_pulse_end", fs_a, 1'b0);
            if (k == 97) chk("hs_low_end", hs_a, 1'b0);
            if (k == 98) chk("hs_rise", hs_a, 1'b1);
        end
        chk("hs_low_count", low, 96);
        tick_n(1);
        chk("hs_wrap", hs_a, 1'b0);
        tick_n(799);
        chk("vs_low", vs_a, 1'b0);
        tick_n(1);
        chk("vs_rise", vs_a, 1'b1);

        // Scale 2 instance, shown from the first frame
        probe(385, 159);
        chk("s2_faddr", p_fa_b, 12'h470);
        chk("s2_col0", p_rgb_b, 8'hF1);
        probe(386, 159);
        chk("s2_col1", p_rgb_b, 8'h03);
        probe(388, 159);
        chk("s2_col2", p_rgb_b, 8'hF4);
        probe(386, 161);
        chk("s2_row1", p_fa_b, 12'h471);
        probe(402, 159);
        chk("s2_code0", p_rgb_b, 8'h82);
        probe(383, 159);
        chk("s2_left", p_rgb_b, 8'hEF);

        // Instance A still hidden
        probe(424, 175);
        chk("fetch_addr", p_fa_a, 12'h470);
        chk("fetch_bgxy", {p_bgx_a, p_bgy_a}, {10'd280, 10'd144});
        chk("fetch_col0", p_rgb_a, 8'h98);
        probe(425, 175);
        chk("hidden_bg", p_rgb_a, 8'h99);
        probe(100, 175);
        chk("blank_rgb", p_rgb_a, 8'h00);
        chk("blank_bgx", p_bgx_a, 10'd0);

        // Reveal two frames per character
        show_a = 1'b1;
        next_frame();
        chk("rev_entry", rev_a, 1'b0);
        probe(425, 175);
        chk("rev_cv0", p_rgb_a, 8'h99);
        next_frame(); next_frame();
        probe(425, 175);
        chk("rev_cv1_c0", p_rgb_a, 8'h03);
        probe(433, 175);
        chk("rev_cv1_c1", p_rgb_a, 8'hA1);
        next_frame(); next_frame();
        probe(433, 175);
        chk("rev_cv2_c1", p_rgb_a, 8'h03);
        repeat (4) next_frame();
        probe(449, 175);
        chk("rev_cv4_c3", p_rgb_a, 8'h03);
        probe(458, 175);
        chk("rev_cv4_c4", p_rgb_a, 8'hBA);

        // Hide mid-reveal, then restart from zero
        show_a = 1'b0;
        next_frame();
        chk("hide_rev", rev_a, 1'b0);
        probe(449, 175);
        chk("hide_c3", p_rgb_a, 8'hB1);
        show_a = 1'b1;
        next_frame();
        probe(425, 175);
        chk("restart_cv0", p_rgb_a, 8'h99);
        repeat (19) next_frame();
        chk("rev_before_done", rev_a, 1'b0);
        show_a = 1'b0;
        next_frame();
        chk("simul_hidden", rev_a, 1'b0);
        probe(425, 175);
        chk("simul_bg", p_rgb_a, 8'h99);

        // Full reveal takes 20 frames after entry
        show_a = 1'b1;
        repeat (20) next_frame();
        chk("rev_20", rev_a, 1'b0);
        next_frame();
        chk("rev_21", rev_a, 1'b1);
        probe(425, 175);
        chk("shown_c0", p_rgb_a, 8'h03);
        probe(498, 175);
        chk("shown_c9", p_rgb_a, 8'h03);

        // Blink (3 frames on, 3 off) when enabled; steady otherwise
        next_frame(); next_frame();
        probe(425, 175);
        chk("blink_on3", p_rgb_a, 8'h03);
        next_frame();
        probe(425, 175);
        chk("blink_off1", p_rgb_a, BLINK_OFF);
        next_frame(); next_frame();
        probe(425, 175);
        chk("blink_off3", p_rgb_a, BLINK_OFF);
        next_frame();
        probe(425, 175);
        chk("blink_on_again", p_rgb_a, 8'h03);

        // Message change applies on next fetch without restarting
        msg_a[79:72] = "H";
        probe(425, 175);
        chk("msg_change_addr", p_fa_a, 12'h480);
        chk("msg_change_rev", rev_a, 1'b1);

        // Reset mid-frame
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rev", rev_a, 1'b0);
        chk("midrst_rgb", rgb_a, 8'h00);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_fs", fs_a, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
